rep_str_agu: RTL and testbench

Iterative address generator for x86 string instructions (MOVS, STOS, LODS, with or without REP) in the execute stage. It latches ESI/EDI/ECX and the direction flag, then issues one memory request per element over a valid/ready handshake. After each accepted request it steps the pointers by the element size (plus or minus, per DF) and counts ECX down. At completion it returns the final register values with a one-cycle done pulse. It is the sequential successor to the single-step pointer-increment path in the execute ALU, generalised in width and address-size mode.

---
 rtl/rep_str_agu_if.sv | 22 ++
 rtl/rep_str_agu.sv | 162 ++++++++++++++++
 tb/tb_rep_str_agu.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/rep_str_agu_if.sv
// Memory request channel between the string AGU and the load/store unit.
interface rep_str_agu_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_rd_en;
  logic              req_wr_en;
  logic [ADDR_W-1:0] req_rd_addr;
  logic [ADDR_W-1:0] req_wr_addr;
  logic [1:0]        req_size;

  modport master (
    output req_valid, req_rd_en, req_wr_en, req_rd_addr, req_wr_addr, req_size,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_rd_en, req_wr_en, req_rd_addr, req_wr_addr, req_size,
    output req_ready
  );
endinterface

// File: rtl/rep_str_agu.sv
// Iterative address generator for MOVS/STOS/LODS with optional REP prefix.
// One memory request per element; ESI/EDI step by +/- element size, ECX counts down.
module rep_str_agu #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [1:0]        op_i,
  input  logic              rep_i,
  input  logic              addr16_i,
  input  logic              df_i,
  input  logic [1:0]        size_i,
  input  logic [ADDR_W-1:0] esi_i,
  input  logic [ADDR_W-1:0] edi_i,
  input  logic [ADDR_W-1:0] ecx_i,
  input  logic              abort_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] esi_o,
  output logic [ADDR_W-1:0] edi_o,
  output logic [ADDR_W-1:0] ecx_o,
  rep_str_agu_if.master     req
);

  localparam logic [1:0] OP_MOVS = 2'b00;
  localparam logic [1:0] OP_STOS = 2'b01;
  localparam logic [1:0] OP_LODS = 2'b10;
  localparam logic [1:0] OP_RSV  = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_ISSUE, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] esi_q, esi_d, edi_q, edi_d, ecx_q, ecx_d;
  logic [1:0]        op_q, op_d, size_q, size_d;
  logic              rep_q, rep_d, addr16_q, addr16_d, df_q, df_d;
  logic              busy_q, done_q, valid_q, rd_en_q, wr_en_q;
  logic [ADDR_W-1:0] bytes, delta, ecx_dec;
  logic              hs;

  // In 16-bit mode only the low half moves; the upper bits pass through untouched.
  function automatic logic [ADDR_W-1:0] step_ptr(input logic [ADDR_W-1:0] p,
                                                 input logic [ADDR_W-1:0] d,
                                                 input logic a16);
    logic [ADDR_W-1:0] r;
    r = p + d;
    if (a16) begin
      r       = p;
      r[15:0] = p[15:0] + d[15:0];
    end
    return r;
  endfunction

  function automatic logic cnt_zero(input logic [ADDR_W-1:0] c, input logic a16);
    return a16 ? (c[15:0] == 16'd0) : (c == ADDR_W'(0));
  endfunction

  function automatic logic op_reads(input logic [1:0] o);
    return (o == OP_MOVS) || (o == OP_LODS);
  endfunction

  function automatic logic op_writes(input logic [1:0] o);
    return (o == OP_MOVS) || (o == OP_STOS);
  endfunction

  assign bytes   = ADDR_W'(1) << size_q;
  assign delta   = df_q ? (ADDR_W'(0) - bytes) : bytes;
  assign ecx_dec = step_ptr(ecx_q, {ADDR_W{1'b1}}, addr16_q);
  assign hs      = valid_q & req.req_ready;

  always_comb begin
    state_d  = state_q;
    esi_d    = esi_q;
    edi_d    = edi_q;
    ecx_d    = ecx_q;
    op_d     = op_q;
    size_d   = size_q;
    rep_d    = rep_q;
    addr16_d = addr16_q;
    df_d     = df_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          esi_d    = esi_i;
          edi_d    = edi_i;
          ecx_d    = ecx_i;
          op_d     = op_i;
          size_d   = size_i;
          rep_d    = rep_i;
          addr16_d = addr16_i;
          df_d     = df_i;
          state_d  = (op_i == OP_RSV) ? S_DONE : S_CHECK;
        end
      end
      S_CHECK: begin
        if (rep_q && cnt_zero(ecx_q, addr16_q)) state_d = S_DONE;
        else if (abort_i)                        state_d = S_DONE;
        else                                     state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (hs) begin
          if (op_reads(op_q))  esi_d = step_ptr(esi_q, delta, addr16_q);
          if (op_writes(op_q)) edi_d = step_ptr(edi_q, delta, addr16_q);
          if (rep_q)           ecx_d = ecx_dec;
          if (!rep_q || cnt_zero(ecx_dec, addr16_q) || abort_i) state_d = S_DONE;
        end else if (abort_i) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Status and request strobes are registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      esi_q    <= '0;
      edi_q    <= '0;
      ecx_q    <= '0;
      op_q     <= '0;
      size_q   <= '0;
      rep_q    <= 1'b0;
      addr16_q <= 1'b0;
      df_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
      rd_en_q  <= 1'b0;
      wr_en_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      esi_q    <= esi_d;
      edi_q    <= edi_d;
      ecx_q    <= ecx_d;
      op_q     <= op_d;
      size_q   <= size_d;
      rep_q    <= rep_d;
      addr16_q <= addr16_d;
      df_q     <= df_d;
      busy_q   <= (state_d != S_IDLE);
      done_q   <= (state_d == S_DONE);
      valid_q  <= (state_d == S_ISSUE);
      rd_en_q  <= (state_d == S_ISSUE) && op_reads(op_d);
      wr_en_q  <= (state_d == S_ISSUE) && op_writes(op_d);
    end
  end

  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign esi_o           = esi_q;
  assign edi_o           = edi_q;
  assign ecx_o           = ecx_q;
  assign req.req_valid   = valid_q;
  assign req.req_rd_en   = rd_en_q;
  assign req.req_wr_en   = wr_en_q;
  assign req.req_rd_addr = esi_q;
  assign req.req_wr_addr = edi_q;
  assign req.req_size    = size_q;

endmodule

// File: tb/tb_rep_str_agu.sv
// Directed bench for rep_str_agu: runs string ops and compares the request trace and results.
module tb_rep_str_agu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, rep, a16, df, abort;
  logic [1:0]  op, size;
  logic [31:0] esi, edi, ecx;
  logic        busy, done;
  logic [31:0] esi_o, edi_o, ecx_o;

  rep_str_agu_if #(.ADDR_W(32)) bus ();

  rep_str_agu #(.ADDR_W(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start),
    .op_i     (op),
    .rep_i    (rep),
    .addr16_i (a16),
    .df_i     (df),
    .size_i   (size),
    .esi_i    (esi),
    .edi_i    (edi),
    .ecx_i    (ecx),
    .abort_i  (abort),
    .busy_o   (busy),
    .done_o   (done),
    .esi_o    (esi_o),
    .edi_o    (edi_o),
    .ecx_o    (ecx_o),
    .req      (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Trace captured by run()
  int          n_hs, done_cyc;
  logic        any_valid;
  logic [31:0] rd_log [8];
  logic [31:0] wr_log [8];
  logic        rden_log [8];
  logic        wren_log [8];
  logic [1:0]  size_log [8];
  logic [31:0] f_esi, f_edi, f_ecx;

  // Cycle k after the start edge uses rdy_pat[k]; abort is high only in cycle abort_cyc.
  task automatic run(input logic [1:0] t_op, input logic t_rep, input logic t_a16,
                     input logic t_df, input logic [1:0] t_size,
                     input logic [31:0] t_esi, input logic [31:0] t_edi,
                     input logic [31:0] t_ecx, input logic [63:0] rdy_pat,
                     input int abort_cyc);
    int cyc;
    op = t_op; rep = t_rep; a16 = t_a16; df = t_df; size = t_size;
    esi = t_esi; edi = t_edi; ecx = t_ecx;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    esi = 32'hDEAD_BEEF; edi = 32'hDEAD_BEEF; ecx = 32'hDEAD_BEEF;
    cyc = 1; n_hs = 0; done_cyc = -1; any_valid = 1'b0;
    f_esi = '0; f_edi = '0; f_ecx = '0;
    while (cyc < 48 && done_cyc < 0) begin
      bus.req_ready = rdy_pat[6'(cyc)];
      abort = (cyc == abort_cyc);
      #1;
      if (done) begin
        done_cyc = cyc; f_esi = esi_o; f_edi = edi_o; f_ecx = ecx_o;
      end
      if (bus.req_valid) any_valid = 1'b1;
      if (bus.req_valid && bus.req_ready && n_hs < 8) begin
        rd_log[n_hs]   = bus.req_rd_addr;
        wr_log[n_hs]   = bus.req_wr_addr;
        rden_log[n_hs] = bus.req_rd_en;
        wren_log[n_hs] = bus.req_wr_en;
        size_log[n_hs] = bus.req_size;
        n_hs++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.req_ready = 1'b0;
    abort = 1'b0;
  endtask

  task automatic check_idle_after(input string tag);
    check({tag, "_busy_after"}, 32'(busy), 0);
    check({tag, "_done_after"}, 32'(done), 0);
  endtask

  localparam logic [63:0] ALL = {64{1'b1}};

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 2'b00; rep = 1'b0; a16 = 1'b0; df = 1'b0;
    size = 2'b00; esi = '0; edi = '0; ecx = '0; abort = 1'b0; bus.req_ready = 1'b0;
    #12;
    check("rst_busy",  32'(busy), 0);
    check("rst_done",  32'(done), 0);
    check("rst_valid", 32'(bus.req_valid), 0);
    check("rst_esi",   esi_o, 0);
    check("rst_ecx",   ecx_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // MOVS, no REP, dword
    run(2'b00, 1'b0, 1'b0, 1'b0, 2'b10, 32'h1000, 32'h2000, 32'h5, ALL, -1);
    check("movs_nhs",  n_hs, 1);
    check("movs_rd",   rd_log[0], 32'h1000);
    check("movs_wr",   wr_log[0], 32'h2000);
    check("movs_rden", 32'(rden_log[0]), 1);
    check("movs_wren", 32'(wren_log[0]), 1);
    check("movs_size", 32'(size_log[0]), 2);
    check("movs_done", done_cyc, 3);
    check("movs_esi",  f_esi, 32'h1004);
    check("movs_edi",  f_edi, 32'h2004);
    check("movs_ecx",  f_ecx, 32'h5);
    check_idle_after("movs");

    // REP STOS byte, decrement
    run(2'b01, 1'b1, 1'b0, 1'b1, 2'b00, 32'h500, 32'h10, 32'h3, ALL, -1);
    check("stos_nhs",  n_hs, 3);
    check("stos_wr0",  wr_log[0], 32'h10);
    check("stos_wr1",  wr_log[1], 32'h0F);
    check("stos_wr2",  wr_log[2], 32'h0E);
    check("stos_rden", 32'(rden_log[0]), 0);
    check("stos_wren", 32'(wren_log[2]), 1);
    check("stos_done", done_cyc, 5);
    check("stos_edi",  f_edi, 32'h0D);
    check("stos_ecx",  f_ecx, 32'h0);
    check("stos_esi",  f_esi, 32'h500);

    // REP LODS with zero count
    run(2'b10, 1'b1, 1'b0, 1'b0, 2'b10, 32'h300, 32'h400, 32'h0, ALL, -1);
    check("lods0_valid", 32'(any_valid), 0);
    check("lods0_done",  done_cyc, 2);
    check("lods0_esi",   f_esi, 32'h300);
    check("lods0_edi",   f_edi, 32'h400);
    check("lods0_ecx",   f_ecx, 32'h0);

    // 16-bit address size wraps the low half only
    run(2'b00, 1'b1, 1'b1, 1'b0, 2'b01, 32'hABCD_FFFE, 32'h1234_0010, 32'h5555_0002, ALL, -1);
    check("a16_nhs", n_hs, 2);
    check("a16_rd0", rd_log[0], 32'hABCD_FFFE);
    check("a16_rd1", rd_log[1], 32'hABCD_0000);
    check("a16_wr1", wr_log[1], 32'h1234_0012);
    check("a16_done", done_cyc, 4);
    check("a16_esi", f_esi, 32'hABCD_0002);
    check("a16_edi", f_edi, 32'h1234_0014);
    check("a16_ecx", f_ecx, 32'h5555_0000);

    // 32-bit pointer wrap downward, qword
    run(2'b01, 1'b0, 1'b0, 1'b1, 2'b11, 32'h0, 32'h4, 32'h9, ALL, -1);
    check("wrap_wr",  wr_log[0], 32'h4);
    check("wrap_edi", f_edi, 32'hFFFF_FFFC);
    check("wrap_ecx", f_ecx, 32'h9);

    // Abort in a stalled cycle after the 2nd handshake
    run(2'b00, 1'b1, 1'b0, 1'b0, 2'b10, 32'h100, 32'h200, 32'd10, 64'h14, 5);
    check("abst_nhs",  n_hs, 2);
    check("abst_done", done_cyc, 6);
    check("abst_ecx",  f_ecx, 32'd8);
    check("abst_esi",  f_esi, 32'h108);
    check("abst_edi",  f_edi, 32'h208);

    // Abort together with the 3rd handshake
    run(2'b00, 1'b1, 1'b0, 1'b0, 2'b10, 32'h100, 32'h200, 32'd10, 64'h34, 5);
    check("abhs_nhs",  n_hs, 3);
    check("abhs_done", done_cyc, 6);
    check("abhs_ecx",  f_ecx, 32'd7);
    check("abhs_esi",  f_esi, 32'h10C);

    // Abort seen in CHECK
    run(2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 32'h100, 32'h200, 32'd5, ALL, 1);
    check("abck_valid", 32'(any_valid), 0);
    check("abck_done",  done_cyc, 2);
    check("abck_ecx",   f_ecx, 32'd5);

    // Reserved op
    run(2'b11, 1'b1, 1'b0, 1'b0, 2'b00, 32'h11, 32'h22, 32'h33, ALL, -1);
    check("rsv_valid", 32'(any_valid), 0);
    check("rsv_done",  done_cyc, 1);
    check("rsv_esi",   f_esi, 32'h11);
    check("rsv_ecx",   f_ecx, 32'h33);

    // Asynchronous reset in the middle of REP STOS
    op = 2'b01; rep = 1'b1; a16 = 1'b0; df = 1'b0; size = 2'b00;
    esi = 32'h0; edi = 32'h800; ecx = 32'd10;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    bus.req_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("mid_valid_pre", 32'(bus.req_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_busy",  32'(busy), 0);
    check("mid_valid", 32'(bus.req_valid), 0);
    check("mid_done",  32'(done), 0);
    check("mid_edi",   edi_o, 0);
    bus.req_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run(2'b01, 1'b1, 1'b0, 1'b1, 2'b00, 32'h500, 32'h10, 32'h3, ALL, -1);
    check("post_nhs",  n_hs, 3);
    check("post_done", done_cyc, 5);
    check("post_edi",  f_edi, 32'h0D);
    check("post_ecx",  f_ecx, 32'h0);
    check_idle_after("post");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
